id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register: the stage directly upstream of the ALU in the 5-stage MIPS datapath.
//  Registers the decoded instruction, then drives ALU A/B/ALUControl through EX/MEM and MEM/WB forwarding.
//  Detects load-use hazards, reports them upstream, and inserts a bubble itself.
//  Supports stall (hold plus operand refresh) and flush (bubble).
// PARAMETERS
//  DW        32   datapath width (ALU operands, immediates, results)
//  NOP_CTRL  10   ALUControl code driven for a bubble (ALU nop)
// PORTS
//  Clk            in   1   rising-edge clock
//  Reset_n        in   1   asynchronous, active-low reset
//  Stall          in   1   hold current contents (EX cannot advance)
//  Flush          in   1   replace next contents with a bubble
//  In_Valid       in   1   ID holds a real instruction
//  In_ALUControl  in   4   ALU op code (0 add ... 9 slt, 10 nop)
//  In_ReadData1   in   DW  register-file rs value
//  In_ReadData2   in   DW  register-file rt value
//  In_Imm         in   DW  sign/zero-extended immediate
//  In_Shamt       in   5   shift amount field
//  In_Rs,In_Rt,In_Rd in 5  register specifiers
//  In_ALUSrcA     in   1   0: A=rs, 1: A={27'b0,shamt}
//  In_ALUSrcB     in   1   0: B=rt, 1: B=imm
//  In_RegDst      in   1   0: dest=rt, 1: dest=rd
//  In_RegWrite,In_MemRead,In_MemWrite,In_MemToReg  in 1 each  control for later stages
//  ExMem_RegWrite in   1   ; ExMem_Rd in 5 ; ExMem_Result in DW   (EX/MEM producer)
//  MemWb_RegWrite in   1   ; MemWb_Rd in 5 ; MemWb_Result in DW   (MEM/WB producer)
//  ALU_A, ALU_B   out  DW  ALU operands (post-forwarding, post-mux)
//  ALUControl     out  4   registered ALU op
//  Out_Valid      out  1   EX holds a real instruction
//  Out_WriteReg   out  5   destination register (RegDst already applied)
//  Out_StoreData  out  DW  forwarded rt value for sw
//  Out_RegWrite,Out_MemRead,Out_MemWrite,Out_MemToReg  out 1 each
//  LoadUseHazard  out  1   combinational; upstream IF/ID and PC must hold when 1
// BEHAVIOUR
//  Reset (Reset_n=0, async): all registers 0; ALUControl=NOP_CTRL; Out_Valid=0; ALU_A=ALU_B=0.
//  Registered update priority each edge: Flush > Stall > LoadUseHazard > load.
//   Flush: bubble, i.e. Valid=0, RegWrite/MemRead/MemWrite/MemToReg=0, ALUControl=NOP_CTRL. Overrides Stall.
//   Stall: control and specifiers held; held rs/rt data regs re-captured with their forwarded values,
//          so a producer retiring during the stall is not lost.
//   LoadUseHazard (no Flush/Stall): bubble inserted; the ID instruction is re-offered next cycle by upstream.
//   Otherwise: In_* captured; Out_Valid=In_Valid. When In_Valid=0, controls are captured as bubble.
//  Latency: 1 cycle from ID inputs to registered outputs. Forwarding/muxing is combinational on register outputs.
//  Forwarding (per operand, for held rs and held rt separately):
//   if ExMem_RegWrite && ExMem_Rd!=0 && ExMem_Rd==reg -> ExMem_Result
//   else if MemWb_RegWrite && MemWb_Rd!=0 && MemWb_Rd==reg -> MemWb_Result
//   else held register-file value. EX/MEM wins when both match. $0 is never forwarded.
//  ALU_A = SrcA ? zero-extended shamt : fwd_rs.  ALU_B = SrcB ? imm : fwd_rt.  Out_StoreData = fwd_rt always.
//  LoadUseHazard = Out_Valid & Out_MemRead & Out_WriteReg!=0 & In_Valid &
//                  (Out_WriteReg==In_Rs | Out_WriteReg==In_Rt).
//  Reset mid-stall or mid-hazard: everything clears immediately; the next instruction loads normally.
// TESTING
//  1 Reset asserted mid-run -> all outputs 0, ALUControl=10, Out_Valid=0, asynchronously before next edge.
//  2 add $3,$1,$2 (rf 5,7), ExMem writes $1=100 and MemWb writes $1=50 -> ALU_A=100, ALU_B=7.
//  3 lw $4 in EX, then ID add $5,$4,$4 -> LoadUseHazard=1; next edge Out_Valid=0; then add loads once.
//  4 Stall 3 cycles while MemWb writes $2=9 only in cycle 1 -> ALU_B stays 9 all 3 cycles.
//  5 Flush and Stall together -> bubble (Out_RegWrite=0, ALUControl=10); Flush wins.
//  6 sll $6,$7,4 (SrcA=1) with ExMem_Rd=0, ExMem_Result=0xDEAD -> ALU_A=4, no forward from $0.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU: operand forwarding from EX/MEM and MEM/WB,
// load-use hazard detection with self-inserted bubble, stall (hold + operand refresh) and flush.
module id_ex_stage #(
  parameter int unsigned DW       = 32,
  parameter logic [3:0]  NOP_CTRL = 4'd10
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          Stall,
  input  logic          Flush,
  input  logic          In_Valid,
  input  logic [3:0]    In_ALUControl,
  input  logic [DW-1:0] In_ReadData1,
  input  logic [DW-1:0] In_ReadData2,
  input  logic [DW-1:0] In_Imm,
  input  logic [4:0]    In_Shamt,
  input  logic [4:0]    In_Rs,
  input  logic [4:0]    In_Rt,
  input  logic [4:0]    In_Rd,
  input  logic          In_ALUSrcA,
  input  logic          In_ALUSrcB,
  input  logic          In_RegDst,
  input  logic          In_RegWrite,
  input  logic          In_MemRead,
  input  logic          In_MemWrite,
  input  logic          In_MemToReg,
  input  logic          ExMem_RegWrite,
  input  logic [4:0]    ExMem_Rd,
  input  logic [DW-1:0] ExMem_Result,
  input  logic          MemWb_RegWrite,
  input  logic [4:0]    MemWb_Rd,
  input  logic [DW-1:0] MemWb_Result,
  output logic [DW-1:0] ALU_A,
  output logic [DW-1:0] ALU_B,
  output logic [3:0]    ALUControl,
  output logic          Out_Valid,
  output logic [4:0]    Out_WriteReg,
  output logic [DW-1:0] Out_StoreData,
  output logic          Out_RegWrite,
  output logic          Out_MemRead,
  output logic          Out_MemWrite,
  output logic          Out_MemToReg,
  output logic          LoadUseHazard
);

  localparam int unsigned RW = 5;

  logic          valid_q,    valid_d;
  logic [3:0]    alu_ctrl_q, alu_ctrl_d;
  logic [DW-1:0] rd1_q,      rd1_d;
  logic [DW-1:0] rd2_q,      rd2_d;
  logic [DW-1:0] imm_q,      imm_d;
  logic [RW-1:0] shamt_q,    shamt_d;
  logic [RW-1:0] rs_q,       rs_d;
  logic [RW-1:0] rt_q,       rt_d;
  logic [RW-1:0] wreg_q,     wreg_d;
  logic          srca_q,     srca_d;
  logic          srcb_q,     srcb_d;
  logic          regwr_q,    regwr_d;
  logic          memrd_q,    memrd_d;
  logic          memwr_q,    memwr_d;
  logic          mem2reg_q,  mem2reg_d;

  logic [DW-1:0] fwd_rs, fwd_rt;

  // Forwarding: EX/MEM beats MEM/WB, $0 never forwarded
  always_comb begin
    fwd_rs = rd1_q;
    if (ExMem_RegWrite && (ExMem_Rd != '0) && (ExMem_Rd == rs_q)) begin
      fwd_rs = ExMem_Result;
    end else if (MemWb_RegWrite && (MemWb_Rd != '0) && (MemWb_Rd == rs_q)) begin
      fwd_rs = MemWb_Result;
    end
    fwd_rt = rd2_q;
    if (ExMem_RegWrite && (ExMem_Rd != '0) && (ExMem_Rd == rt_q)) begin
      fwd_rt = ExMem_Result;
    end else if (MemWb_RegWrite && (MemWb_Rd != '0) && (MemWb_Rd == rt_q)) begin
      fwd_rt = MemWb_Result;
    end
  end

  assign LoadUseHazard = valid_q & memrd_q & (wreg_q != '0) & In_Valid &
                         ((wreg_q == In_Rs) | (wreg_q == In_Rt));

  assign ALU_A         = srca_q ? DW'(shamt_q) : fwd_rs;
  assign ALU_B         = srcb_q ? imm_q : fwd_rt;
  assign Out_StoreData = fwd_rt;
  assign ALUControl    = alu_ctrl_q;
  assign Out_Valid     = valid_q;
  assign Out_WriteReg  = wreg_q;
  assign Out_RegWrite  = regwr_q;
  assign Out_MemRead   = memrd_q;
  assign Out_MemWrite  = memwr_q;
  assign Out_MemToReg  = mem2reg_q;

  // Next-state: Flush > Stall > LoadUseHazard > load
  always_comb begin
    valid_d    = valid_q;
    alu_ctrl_d = alu_ctrl_q;
    rd1_d      = rd1_q;
    rd2_d      = rd2_q;
    imm_d      = imm_q;
    shamt_d    = shamt_q;
    rs_d       = rs_q;
    rt_d       = rt_q;
    wreg_d     = wreg_q;
    srca_d     = srca_q;
    srcb_d     = srcb_q;
    regwr_d    = regwr_q;
    memrd_d    = memrd_q;
    memwr_d    = memwr_q;
    mem2reg_d  = mem2reg_q;
    if (Flush || (!Stall && LoadUseHazard)) begin
      valid_d    = 1'b0;
      alu_ctrl_d = NOP_CTRL;
      regwr_d    = 1'b0;
      memrd_d    = 1'b0;
      memwr_d    = 1'b0;
      mem2reg_d  = 1'b0;
    end else if (Stall) begin
      // Refresh held operands so a producer retiring during the stall is kept
      rd1_d = fwd_rs;
      rd2_d = fwd_rt;
    end else begin
      valid_d    = In_Valid;
      alu_ctrl_d = In_Valid ? In_ALUControl : NOP_CTRL;
      rd1_d      = In_ReadData1;
      rd2_d      = In_ReadData2;
      imm_d      = In_Imm;
      shamt_d    = In_Shamt;
      rs_d       = In_Rs;
      rt_d       = In_Rt;
      wreg_d     = In_RegDst ? In_Rd : In_Rt;
      srca_d     = In_ALUSrcA;
      srcb_d     = In_ALUSrcB;
      regwr_d    = In_Valid & In_RegWrite;
      memrd_d    = In_Valid & In_MemRead;
      memwr_d    = In_Valid & In_MemWrite;
      mem2reg_d  = In_Valid & In_MemToReg;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      valid_q    <= 1'b0;
      alu_ctrl_q <= NOP_CTRL;
      rd1_q      <= '0;
      rd2_q      <= '0;
      imm_q      <= '0;
      shamt_q    <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      wreg_q     <= '0;
      srca_q     <= 1'b0;
      srcb_q     <= 1'b0;
      regwr_q    <= 1'b0;
      memrd_q    <= 1'b0;
      memwr_q    <= 1'b0;
      mem2reg_q  <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      alu_ctrl_q <= alu_ctrl_d;
      rd1_q      <= rd1_d;
      rd2_q      <= rd2_d;
      imm_q      <= imm_d;
      shamt_q    <= shamt_d;
      rs_q       <= rs_d;
      rt_q       <= rt_d;
      wreg_q     <= wreg_d;
      srca_q     <= srca_d;
      srcb_q     <= srcb_d;
      regwr_q    <= regwr_d;
      memrd_q    <= memrd_d;
      memwr_q    <= memwr_d;
      mem2reg_q  <= mem2reg_d;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized traffic
// compared against an instruction-level model of the EX slot.
module tb_id_ex_stage;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        Stall, Flush, In_Valid;
  logic [3:0]  In_ALUControl;
  logic [31:0] In_ReadData1, In_ReadData2, In_Imm;
  logic [4:0]  In_Shamt, In_Rs, In_Rt, In_Rd;
  logic        In_ALUSrcA, In_ALUSrcB, In_RegDst;
  logic        In_RegWrite, In_MemRead, In_MemWrite, In_MemToReg;
  logic        ExMem_RegWrite, MemWb_RegWrite;
  logic [4:0]  ExMem_Rd, MemWb_Rd;
  logic [31:0] ExMem_Result, MemWb_Result;
  logic [31:0] ALU_A, ALU_B, Out_StoreData;
  logic [3:0]  ALUControl;
  logic        Out_Valid;
  logic [4:0]  Out_WriteReg;
  logic        Out_RegWrite, Out_MemRead, Out_MemWrite, Out_MemToReg;
  logic        LoadUseHazard;

  int n_cmp = 0;
  int n_err = 0;

  id_ex_stage #(.DW(32), .NOP_CTRL(4'd10)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Stall(Stall), .Flush(Flush), .In_Valid(In_Valid),
    .In_ALUControl(In_ALUControl), .In_ReadData1(In_ReadData1), .In_ReadData2(In_ReadData2),
    .In_Imm(In_Imm), .In_Shamt(In_Shamt), .In_Rs(In_Rs), .In_Rt(In_Rt), .In_Rd(In_Rd),
    .In_ALUSrcA(In_ALUSrcA), .In_ALUSrcB(In_ALUSrcB), .In_RegDst(In_RegDst),
    .In_RegWrite(In_RegWrite), .In_MemRead(In_MemRead), .In_MemWrite(In_MemWrite),
    .In_MemToReg(In_MemToReg),
    .ExMem_RegWrite(ExMem_RegWrite), .ExMem_Rd(ExMem_Rd), .ExMem_Result(ExMem_Result),
    .MemWb_RegWrite(MemWb_RegWrite), .MemWb_Rd(MemWb_Rd), .MemWb_Result(MemWb_Result),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALUControl(ALUControl), .Out_Valid(Out_Valid),
    .Out_WriteReg(Out_WriteReg), .Out_StoreData(Out_StoreData), .Out_RegWrite(Out_RegWrite),
    .Out_MemRead(Out_MemRead), .Out_MemWrite(Out_MemWrite), .Out_MemToReg(Out_MemToReg),
    .LoadUseHazard(LoadUseHazard)
  );

  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_idle();
    Stall = 0; Flush = 0; In_Valid = 0; In_ALUControl = 0;
    In_ReadData1 = 0; In_ReadData2 = 0; In_Imm = 0; In_Shamt = 0;
    In_Rs = 0; In_Rt = 0; In_Rd = 0; In_ALUSrcA = 0; In_ALUSrcB = 0; In_RegDst = 0;
    In_RegWrite = 0; In_MemRead = 0; In_MemWrite = 0; In_MemToReg = 0;
    ExMem_RegWrite = 0; ExMem_Rd = 0; ExMem_Result = 0;
    MemWb_RegWrite = 0; MemWb_Rd = 0; MemWb_Result = 0;
  endtask

  // R-type "op $rd,$rs,$rt" with given register-file values
  task automatic drive_rtype(input logic [4:0] rd, rs, rt, input logic [31:0] v1, v2);
    In_Valid = 1; In_ALUControl = 0; In_RegDst = 1; In_RegWrite = 1;
    In_MemRead = 0; In_MemWrite = 0; In_MemToReg = 0; In_ALUSrcA = 0; In_ALUSrcB = 0;
    In_Rs = rs; In_Rt = rt; In_Rd = rd; In_ReadData1 = v1; In_ReadData2 = v2;
  endtask

  // Model of the instruction sitting in EX, tracked as operand values rather than raw fields
  typedef struct {
    bit          valid;
    logic [3:0]  op;
    logic [31:0] rs_val, rt_val, imm;
    logic [4:0]  shamt, rs, rt, dest;
    bit          use_shamt, use_imm, rw, mr, mw, m2r;
  } ex_t;

  function automatic ex_t bubble_m();
    ex_t e;
    e = '{valid: 0, op: 4'd10, rs_val: 0, rt_val: 0, imm: 0, shamt: 0, rs: 0, rt: 0,
          dest: 0, use_shamt: 0, use_imm: 0, rw: 0, mr: 0, mw: 0, m2r: 0};
    return e;
  endfunction

  // Current architectural value of register r given the in-flight producers
  function automatic logic [31:0] value_of(input logic [4:0] r, input logic [31:0] stale);
    if (r == 0) return stale;
    if (ExMem_RegWrite && ExMem_Rd == r) return ExMem_Result;
    if (MemWb_RegWrite && MemWb_Rd == r) return MemWb_Result;
    return stale;
  endfunction

  ex_t m, nx;

  initial begin
    logic exp_haz;
    drive_idle();
    Reset_n = 0;
    #12;
    check_eq("reset_valid", 32'(Out_Valid), 0);
    check_eq("reset_aluctrl", 32'(ALUControl), 10);
    check_eq("reset_alua", ALU_A, 0);
    check_eq("reset_alub", ALU_B, 0);
    @(negedge Clk); Reset_n = 1;

    // add $3,$1,$2 with both producers writing $1: EX/MEM must win
    drive_rtype(3, 1, 2, 5, 7);
    @(posedge Clk);
    @(negedge Clk);
    drive_idle();
    ExMem_RegWrite = 1; ExMem_Rd = 1; ExMem_Result = 100;
    MemWb_RegWrite = 1; MemWb_Rd = 1; MemWb_Result = 50;
    #1;
    check_eq("fwd_alua_exmem", ALU_A, 100);
    check_eq("fwd_alub_rf", ALU_B, 7);
    check_eq("fwd_writereg", 32'(Out_WriteReg), 3);

    // Asynchronous reset mid-run clears everything before the next edge
    #2 Reset_n = 0;
    #1;
    check_eq("midrst_valid", 32'(Out_Valid), 0);
    check_eq("midrst_aluctrl", 32'(ALUControl), 10);
    check_eq("midrst_regwrite", 32'(Out_RegWrite), 0);
    check_eq("midrst_alua", ALU_A, 0);
    check_eq("midrst_alub", ALU_B, 0);
    @(negedge Clk); Reset_n = 1; drive_idle();
    drive_rtype(9, 10, 11, 32'h11, 32'h22);
    @(posedge Clk); #1;
    check_eq("postrst_valid", 32'(Out_Valid), 1);
    check_eq("postrst_alub", ALU_B, 32'h22);

    // lw $4 in EX, then add $5,$4,$4 in ID -> hazard, bubble, then add loads
    @(negedge Clk); drive_idle();
    In_Valid = 1; In_MemRead = 1; In_RegWrite = 1; In_MemToReg = 1; In_ALUSrcB = 1;
    In_Rt = 4; In_Imm = 8;
    @(posedge Clk);
    @(negedge Clk);
    drive_rtype(5, 4, 4, 1, 1);
    #1;
    check_eq("luh_asserted", 32'(LoadUseHazard), 1);
    @(posedge Clk); #1;
    check_eq("luh_bubble_valid", 32'(Out_Valid), 0);
    check_eq("luh_bubble_ctrl", 32'(ALUControl), 10);
    check_eq("luh_cleared", 32'(LoadUseHazard), 0);
    @(posedge Clk); #1;
    check_eq("luh_add_valid", 32'(Out_Valid), 1);
    check_eq("luh_add_dest", 32'(Out_WriteReg), 5);
    @(negedge Clk); drive_idle();

    // Stall 3 cycles; MemWb writes $2=9 only in the first
    drive_rtype(3, 1, 2, 5, 7);
    @(posedge Clk);
    @(negedge Clk); drive_idle(); Stall = 1;
    MemWb_RegWrite = 1; MemWb_Rd = 2; MemWb_Result = 9;
    #1 check_eq("stall_c1_alub", ALU_B, 9);
    @(negedge Clk); MemWb_RegWrite = 0; MemWb_Result = 0;
    #1 check_eq("stall_c2_alub", ALU_B, 9);
    @(negedge Clk);
    #1 check_eq("stall_c3_alub", ALU_B, 9);
    check_eq("stall_c3_valid", 32'(Out_Valid), 1);

    // Flush with Stall: bubble wins
    @(negedge Clk); drive_idle();
    Flush = 1; Stall = 1;
    drive_rtype(7, 1, 2, 3, 4);
    @(posedge Clk); #1;
    check_eq("flush_regwrite", 32'(Out_RegWrite), 0);
    check_eq("flush_aluctrl", 32'(ALUControl), 10);
    check_eq("flush_valid", 32'(Out_Valid), 0);

    // sll $6,$7,4 with a write to $0 in EX/MEM
    @(negedge Clk); drive_idle();
    drive_rtype(6, 0, 7, 0, 32'h11);
    In_ALUSrcA = 1; In_Shamt = 4; In_ALUControl = 4'd6;
    @(posedge Clk);
    @(negedge Clk); drive_idle();
    ExMem_RegWrite = 1; ExMem_Rd = 0; ExMem_Result = 32'hDEAD;
    #1;
    check_eq("sll_alua", ALU_A, 4);
    check_eq("sll_alub", ALU_B, 32'h11);
    check_eq("sll_aluctrl", 32'(ALUControl), 6);

    // Randomized traffic against the model
    @(negedge Clk); drive_idle(); Reset_n = 0;
    #1 Reset_n = 1;
    m = bubble_m();
    for (int i = 0; i < 500; i++) begin
      @(negedge Clk);
      Stall          = ($urandom_range(0, 5) == 0);
      Flush          = ($urandom_range(0, 11) == 0);
      In_Valid       = ($urandom_range(0, 3) != 0);
      In_ALUControl  = 4'($urandom_range(0, 9));
      In_ReadData1   = $urandom;
      In_ReadData2   = $urandom;
      In_Imm         = $urandom;
      In_Shamt       = 5'($urandom);
      In_Rs          = 5'($urandom_range(0, 3));
      In_Rt          = 5'($urandom_range(0, 3));
      In_Rd          = 5'($urandom_range(0, 3));
      In_ALUSrcA     = ($urandom_range(0, 3) == 0);
      In_ALUSrcB     = 1'($urandom);
      In_RegDst      = 1'($urandom);
      In_RegWrite    = 1'($urandom);
      In_MemRead     = ($urandom_range(0, 2) == 0);
      In_MemWrite    = 1'($urandom);
      In_MemToReg    = 1'($urandom);
      ExMem_RegWrite = 1'($urandom);
      ExMem_Rd       = 5'($urandom_range(0, 3));
      ExMem_Result   = $urandom;
      MemWb_RegWrite = 1'($urandom);
      MemWb_Rd       = 5'($urandom_range(0, 3));
      MemWb_Result   = $urandom;
      #1;
      exp_haz = m.valid && m.mr && m.dest != 0 && In_Valid && (m.dest == In_Rs || m.dest == In_Rt);
      check_eq("rnd_hazard", 32'(LoadUseHazard), 32'(exp_haz));
      check_eq("rnd_valid", 32'(Out_Valid), 32'(m.valid));
      check_eq("rnd_aluctrl", 32'(ALUControl), 32'(m.op));
      check_eq("rnd_regwrite", 32'(Out_RegWrite), 32'(m.rw));
      check_eq("rnd_memread", 32'(Out_MemRead), 32'(m.mr));
      check_eq("rnd_memwrite", 32'(Out_MemWrite), 32'(m.mw));
      check_eq("rnd_memtoreg", 32'(Out_MemToReg), 32'(m.m2r));
      if (m.valid) begin
        check_eq("rnd_alua", ALU_A, m.use_shamt ? 32'(m.shamt) : value_of(m.rs, m.rs_val));
        check_eq("rnd_alub", ALU_B, m.use_imm ? m.imm : value_of(m.rt, m.rt_val));
        check_eq("rnd_store", Out_StoreData, value_of(m.rt, m.rt_val));
        check_eq("rnd_dest", 32'(Out_WriteReg), 32'(m.dest));
      end
      nx = m;
      if (Flush || (!Stall && exp_haz)) begin
        nx = bubble_m();
      end else if (Stall) begin
        nx.rs_val = value_of(m.rs, m.rs_val);
        nx.rt_val = value_of(m.rt, m.rt_val);
      end else if (!In_Valid) begin
        nx = bubble_m();
      end else begin
        nx = '{valid: 1, op: In_ALUControl, rs_val: In_ReadData1, rt_val: In_ReadData2,
               imm: In_Imm, shamt: In_Shamt, rs: In_Rs, rt: In_Rt,
               dest: In_RegDst ? In_Rd : In_Rt, use_shamt: In_ALUSrcA, use_imm: In_ALUSrcB,
               rw: In_RegWrite, mr: In_MemRead, mw: In_MemWrite, m2r: In_MemToReg};
      end
      @(posedge Clk);
      m = nx;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
